j2_io_led_port: RTL and testbench

J2_IO_LED_PORT -- requirements
Module: j2_io_led_port

---
 rtl/j2_io_led_port.sv | 192 +++++++++++++++++++
 tb/tb_j2_io_led_port.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/j2_io_led_port.sv
// IO-mapped LED port: per-channel off/on/blink/one-shot control driven by a
// shared tick prescaler, with registered single-cycle readback.
module j2_io_led_port #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 4,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                clock,
  input  logic                active_low_reset,
  input  logic [15:0]         io_address,
  input  logic                io_write_enable,
  input  logic                io_read_enable,
  input  logic [WIDTH-1:0]    data_in,
  output logic [WIDTH-1:0]    io_data_out,
  output logic                io_read_valid,
  output logic [CHANNELS-1:0] leds
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [15:0] ADDR_RELOAD = 16'h00F0;
  localparam logic [15:0] ADDR_STATUS = 16'h00FF;
  localparam logic [15:0] CH_LIMIT    = 16'(CHANNELS);

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) rst_sync_q <= 2'b00;
    else                   rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // State
  mode_t                    mode_q   [CHANNELS];
  mode_t                    mode_d   [CHANNELS];
  logic [7:0]               period_q [CHANNELS];
  logic [7:0]               period_d [CHANNELS];
  logic [7:0]               cnt_q    [CHANNELS];
  logic [7:0]               cnt_d    [CHANNELS];
  logic [CHANNELS-1:0]      leds_q, leds_d;
  logic [PRESCALE_BITS-1:0] presc_q, presc_d;
  logic [PRESCALE_BITS-1:0] reload_q, reload_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic                     valid_q, valid_d;

  // Decode
  logic                     addr_is_ch;
  logic                     ch_wr;
  logic                     reload_wr;
  logic                     tick;
  logic [PRESCALE_BITS-1:0] reload_wdata;
  logic [WIDTH-1:0]         reload_rdata;
  logic [WIDTH-1:0]         rdata;

  assign addr_is_ch = (io_address < CH_LIMIT);
  assign ch_wr      = io_write_enable && addr_is_ch;
  assign reload_wr  = io_write_enable && (io_address == ADDR_RELOAD);
  assign tick       = (presc_q == reload_q);

  if (PRESCALE_BITS >= WIDTH) begin : g_reload_wide
    always_comb begin
      reload_wdata            = '0;
      reload_wdata[WIDTH-1:0] = data_in;
    end
    assign reload_rdata = reload_q[WIDTH-1:0];
  end else begin : g_reload_narrow
    assign reload_wdata = data_in[PRESCALE_BITS-1:0];
    always_comb begin
      reload_rdata                    = '0;
      reload_rdata[PRESCALE_BITS-1:0] = reload_q;
    end
  end

  // Prescaler: a reload write restarts the count from zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    reload_d = reload_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    if (reload_wr) begin
      reload_d = reload_wdata;
      presc_d  = '0;
    end
  end

  // Channels. cnt+1 >= period also makes period 0 finish on the first tick,
  // so it behaves as period 1; cnt never exceeds 254, so cnt+1 cannot wrap.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    leds_d   = leds_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_wr && (io_address[2:0] == 3'(i))) begin
        mode_d[i]   = mode_t'(data_in[1:0]);
        period_d[i] = data_in[15:8];
        cnt_d[i]    = '0;
        leds_d[i]   = (data_in[1:0] != 2'b00);
      end else begin
        unique case (mode_q[i])
          MODE_OFF: begin
            leds_d[i] = 1'b0;
            cnt_d[i]  = '0;
          end
          MODE_ON: begin
            leds_d[i] = 1'b1;
            cnt_d[i]  = '0;
          end
          MODE_BLINK: begin
            if (tick) begin
              if (cnt_q[i] + 8'd1 >= period_q[i]) begin
                leds_d[i] = ~leds_q[i];
                cnt_d[i]  = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
              end
            end
          end
          MODE_ONESHOT: begin
            if (tick) begin
              if (cnt_q[i] + 8'd1 >= period_q[i]) begin
                leds_d[i] = 1'b0;
                mode_d[i] = MODE_OFF;
                cnt_d[i]  = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Readback sees the pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rdata = '0;
    if (addr_is_ch) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (io_address[2:0] == 3'(i)) rdata[15:0] = {period_q[i], 6'b000000, mode_q[i]};
      end
    end else if (io_address == ADDR_RELOAD) begin
      rdata = reload_rdata;
    end else if (io_address == ADDR_STATUS) begin
      rdata[CHANNELS-1:0] = leds_q;
    end
  end

  always_comb begin
    valid_d = io_read_enable;
    data_d  = io_read_enable ? rdata : data_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these per-channel arrays are a handful of flops, not a RAM, so resetting them is cheap and required.
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      leds_q   <= '0;
      presc_q  <= '0;
      reload_q <= '1;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      leds_q   <= leds_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign leds          = leds_q;
  assign io_data_out   = data_q;
  assign io_read_valid = valid_q;

endmodule

// File: tb/tb_j2_io_led_port.sv
// Directed self-checking bench for j2_io_led_port (default parameters).
module tb_j2_io_led_port;

  logic        clk;
  logic        rst_n;
  logic [15:0] io_address;
  logic        io_write_enable;
  logic        io_read_enable;
  logic [15:0] data_in;
  logic [15:0] io_data_out;
  logic        io_read_valid;
  logic [3:0]  leds;

  int checks;
  int errors;

  j2_io_led_port #(.WIDTH(16), .CHANNELS(4), .PRESCALE_BITS(16)) dut (
    .clock            (clk),
    .active_low_reset (rst_n),
    .io_address       (io_address),
    .io_write_enable  (io_write_enable),
    .io_read_enable   (io_read_enable),
    .data_in          (data_in),
    .io_data_out      (io_data_out),
    .io_read_valid    (io_read_valid),
    .leds             (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the write lands on the following rising edge.
  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_address      = addr;
    data_in         = data;
    io_write_enable = 1'b1;
    @(negedge clk);
    io_write_enable = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [15:0] data, output logic valid);
    @(negedge clk);
    io_address     = addr;
    io_read_enable = 1'b1;
    @(negedge clk);
    io_read_enable = 1'b0;
    data  = io_data_out;
    valid = io_read_valid;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    logic        v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (leds !== 4'h0) begin errors++; $display("FAIL reset_leds: got %h want 0", leds); end
    checks++; if (io_data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", io_data_out); end
    checks++; if (io_read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", io_read_valid); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(16'h0000, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL reset_rd_ch0: valid %b data %h want 1 0000", v, d); end
    do_read(16'h00F0, d, v);
    checks++; if (v !== 1'b1 || d !== 16'hFFFF) begin errors++; $display("FAIL reset_rd_reload: valid %b data %h want 1 ffff", v, d); end
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b0 || io_data_out !== 16'hFFFF) begin errors++; $display("FAIL reset_hold: valid %b data %h want 0 ffff", io_read_valid, io_data_out); end
    checks++; if (leds !== 4'h0) begin errors++; $display("FAIL reset_leds_idle: got %h want 0", leds); end
  endtask

  task automatic test_blink;
    logic exp;
    do_write(16'h00F0, 16'h0000);
    do_write(16'h0001, 16'h0302);
    // Tick every cycle, period 3: three samples high, three low, repeat.
    for (int k = 0; k < 9; k++) begin
      exp = ((k / 3) % 2) == 0;
      checks++; if (leds[1] !== exp) begin errors++; $display("FAIL blink_k%0d: got %b want %b", k, leds[1], exp); end
      @(negedge clk);
    end
    do_write(16'h0001, 16'h0000);
    checks++; if (leds !== 4'h0) begin errors++; $display("FAIL blink_off: got %h want 0", leds); end
  endtask

  task automatic test_oneshot;
    logic [15:0] d;
    logic        v;
    logic        exp;
    // Reload 1 ticks every other cycle; the channel write lands on a tick edge.
    do_write(16'h00F0, 16'h0001);
    do_write(16'h0000, 16'h0203);
    for (int k = 0; k < 6; k++) begin
      exp = (k < 4);
      checks++; if (leds[0] !== exp) begin errors++; $display("FAIL oneshot_k%0d: got %b want %b", k, leds[0], exp); end
      @(negedge clk);
    end
    do_read(16'h0000, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0200) begin errors++; $display("FAIL oneshot_selfclear: valid %b data %h want 1 0200", v, d); end
    // Period 0 acts as period 1.
    do_write(16'h00F0, 16'h0000);
    do_write(16'h0002, 16'h0003);
    checks++; if (leds[2] !== 1'b1) begin errors++; $display("FAIL oneshot_p0_start: got %b want 1", leds[2]); end
    @(negedge clk);
    checks++; if (leds[2] !== 1'b0) begin errors++; $display("FAIL oneshot_p0_end: got %b want 0", leds[2]); end
    do_read(16'h0002, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_p0_mode: got %h want 0000", d); end
  endtask

  task automatic test_rw_collision;
    logic [15:0] d;
    logic        v;
    do_write(16'h0000, 16'h0000);
    @(negedge clk);
    io_address      = 16'h0000;
    data_in         = 16'h0001;
    io_write_enable = 1'b1;
    io_read_enable  = 1'b1;
    @(negedge clk);
    io_write_enable = 1'b0;
    io_read_enable  = 1'b0;
    checks++; if (io_read_valid !== 1'b1 || io_data_out !== 16'h0000) begin errors++; $display("FAIL rw_prewrite: valid %b data %h want 1 0000", io_read_valid, io_data_out); end
    checks++; if (leds[0] !== 1'b1) begin errors++; $display("FAIL rw_led: got %b want 1", leds[0]); end
    do_read(16'h0000, d, v);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL rw_after: got %h want 0001", d); end
  endtask

  task automatic test_unmapped;
    logic [15:0] d;
    logic        v;
    do_write(16'h0050, 16'hFFFF);
    checks++; if (leds !== 4'h1) begin errors++; $display("FAIL unmapped_wr_leds: got %h want 1", leds); end
    do_write(16'h00FF, 16'hFFFF);
    do_write(16'h0004, 16'h0001);
    checks++; if (leds !== 4'h1) begin errors++; $display("FAIL status_wr_leds: got %h want 1", leds); end
    do_read(16'h0050, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL unmapped_rd: valid %b data %h want 1 0000", v, d); end
    do_read(16'h0004, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ch_oob_rd: got %h want 0000", d); end
    do_read(16'h00FF, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0001) begin errors++; $display("FAIL status_rd: valid %b data %h want 1 0001", v, d); end
    do_read(16'h00F0, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reload_untouched: got %h want 0000", d); end
  endtask

  task automatic test_back_to_back;
    do_write(16'h00F0, 16'h0005);
    do_write(16'h0003, 16'h7701);
    @(negedge clk);
    io_address     = 16'h0003;
    io_read_enable = 1'b1;
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b1 || io_data_out !== 16'h7701) begin errors++; $display("FAIL b2b_0: valid %b data %h want 1 7701", io_read_valid, io_data_out); end
    io_address = 16'h00F0;
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b1 || io_data_out !== 16'h0005) begin errors++; $display("FAIL b2b_1: valid %b data %h want 1 0005", io_read_valid, io_data_out); end
    io_address = 16'h00FF;
    @(negedge clk);
    io_read_enable = 1'b0;
    checks++; if (io_read_valid !== 1'b1 || io_data_out !== 16'h0009) begin errors++; $display("FAIL b2b_2: valid %b data %h want 1 0009", io_read_valid, io_data_out); end
    @(negedge clk);
    checks++; if (io_read_valid !== 1'b0 || io_data_out !== 16'h0009) begin errors++; $display("FAIL b2b_hold: valid %b data %h want 0 0009", io_read_valid, io_data_out); end
  endtask

  task automatic test_reset_mid_blink;
    logic [15:0] d;
    logic        v;
    do_write(16'h00F0, 16'h0000);
    do_write(16'h0001, 16'h0302);
    checks++; if (leds !== 4'hB) begin errors++; $display("FAIL mid_pre: got %h want b", leds); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (leds !== 4'h0) begin errors++; $display("FAIL mid_async_clear: got %h want 0", leds); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (leds !== 4'h0) begin errors++; $display("FAIL mid_idle_k%0d: got %h want 0", k, leds); end
    end
    do_read(16'h0001, d, v);
    checks++; if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL mid_ch1: valid %b data %h want 1 0000", v, d); end
    do_read(16'h00F0, d, v);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL mid_reload: got %h want ffff", d); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    io_address      = 16'h0000;
    io_write_enable = 1'b0;
    io_read_enable  = 1'b0;
    data_in         = 16'h0000;
    test_reset();
    test_blink();
    test_oneshot();
    test_rw_collision();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
